// File: rtl/mux_deser_pkg.sv
// Shared types and defaults for the mux bit deserializer.
// Holds the capture FSM state enum, default sizes and the FIFO pointer-width helper.
package mux_deser_pkg;

  localparam int DEF_WORD_W     = 8;
  localparam int DEF_DIV_W      = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_PUSH   = 2'd3
  } state_t;

  // One extra pointer bit separates full from empty when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mux_deser_fifo.sv
// Synchronous FIFO with the head word read directly from flop storage.
// Latency: a push shows at rd_dat on the next cycle. Backpressure: a push while full is refused unless a pop frees the slot that cycle.
module mux_deser_fifo
  import mux_deser_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          wr_ok, rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/mux_bit_deserializer.sv
// Samples the mux bit at a programmable rate into LSB-first words buffered in a FIFO; PARITY_EN adds an even-parity sample.
// Latency: word_valid two cycles after the last sample into an empty FIFO. Backpressure: full FIFO drops the word and sets sticky overflow.
module mux_bit_deserializer
  import mux_deser_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_en,
  input  logic              start,
  input  logic [DIV_W-1:0]  div,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              parity_err,
  output logic              overflow,
  output logic              busy
);

`ifdef PARITY_EN
  localparam int FW = WORD_W + 1;
`else
  localparam int FW = WORD_W;
`endif
  localparam int BCW = $clog2(WORD_W + 1);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, cnt_q;
  logic [WORD_W-1:0] sr_q;
  logic [BCW-1:0]    bitcnt_q;
  logic              overflow_q;
  logic              sampling, tick, sample, last_bit, push, pop, full, fifo_empty;
  logic [FW-1:0]     push_dat, head_dat;
`ifdef PARITY_EN
  logic              pbit_q;
`endif

  assign sampling = (state_q == S_SHIFT) || (state_q == S_PARITY);
  assign tick     = sampling && (cnt_q == div_q);
  assign sample   = tick && bit_en;
  assign last_bit = (bitcnt_q == BCW'(WORD_W - 1));

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: begin
        if (sample && last_bit) begin
`ifdef PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_PUSH;
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: if (sample) state_d = S_PUSH;
`endif
      S_PUSH: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      overflow_q <= 1'b0;
`ifdef PARITY_EN
      pbit_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        div_q    <= div;
        sr_q     <= '0;
        bitcnt_q <= '0;
      end
      // Counter idles at zero so the first tick lands div+1 cycles after start.
      if (sampling) cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
      else          cnt_q <= '0;
      if (state_q == S_SHIFT && sample) begin
        sr_q     <= {bit_in, sr_q[WORD_W-1:1]};
        bitcnt_q <= bitcnt_q + BCW'(1);
      end
`ifdef PARITY_EN
      if (state_q == S_PARITY && sample) pbit_q <= bit_in;
`endif
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

`ifdef PARITY_EN
  assign push_dat   = {pbit_q, sr_q};
  assign parity_err = word_valid && ((^head_dat[WORD_W-1:0]) ^ head_dat[WORD_W]);
`else
  assign push_dat   = sr_q;
  assign parity_err = 1'b0;
`endif

  assign pop        = word_ready && word_valid;
  assign word_valid = !fifo_empty;
  assign word_data  = head_dat[WORD_W-1:0];
  assign overflow   = overflow_q;
  assign busy       = (state_q != S_IDLE);

  mux_deser_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .rd_dat   (head_dat),
    .full     (full),
    .empty    (fifo_empty)
  );

endmodule
